fir_stream_filter: RTL and testbench

- Parametrised N-tap transposed-form FIR filter with AXI-Stream slave input and master output.
- Generalises the single fixed-coefficient tap stage into a complete filter:
  - runtime-loadable coefficient bank
  - true output backpressure
  - per-packet history clearing
  - rounding/shift and saturation to output width
- Sits between the sample source (ADC/DMA stream) and downstream DSP/DMA in the week-3 filter datapath.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_mac_stage.sv | 27 ++
 rtl/fir_stream_filter.sv | 91 +++++++++
 tb/tb_fir_stream_filter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths and round/saturate helper for the FIR stream filter
package fir_pkg;
  localparam int MAX_W = 128;

  function automatic int acc_width(input int data_w, input int coeff_w, input int num_taps);
    return data_w + coeff_w + $clog2(num_taps);
  endfunction

  // Returns {clipped, value}; value is sign-extended to MAX_W bits.
  function automatic logic [MAX_W:0] sat_round(input logic signed [MAX_W-1:0] acc,
                                               input int shift, input int out_w);
    logic signed [MAX_W-1:0] one, r, hi, lo;
    one = MAX_W'(1);
    r   = acc;
    if (shift > 0) r = (acc + (one <<< (shift - 1))) >>> shift;
    hi = (one <<< (out_w - 1)) - one;
    lo = -(one <<< (out_w - 1));
    if (r > hi) return {1'b1, hi};
    if (r < lo) return {1'b1, lo};
    return {1'b0, r};
  endfunction
endpackage

// File: rtl/fir_mac_stage.sv
// rtl/fir_mac_stage.sv - one transposed-form tap: p_k <= c*x + p_next, or zero on clear
module fir_mac_stage
  import fir_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int COEFF_W = 8,
  parameter int ACC_W   = 43
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [COEFF_W-1:0] coeff,
  input  logic signed [DATA_W-1:0]  x,
  input  logic signed [ACC_W-1:0]   p_next,
  input  logic                      advance,
  input  logic                      clear,
  output logic signed [ACC_W-1:0]   p_k
);
  logic signed [ACC_W-1:0] c_ext, x_ext;

  assign c_ext = ACC_W'(coeff);
  assign x_ext = ACC_W'(x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          p_k <= '0;
    else if (advance) p_k <= clear ? '0 : (c_ext * x_ext + p_next);
  end
endmodule

// File: rtl/fir_stream_filter.sv
// rtl/fir_stream_filter.sv - N-tap transposed FIR with AXI-Stream in/out and loadable coefficients
module fir_stream_filter
  import fir_pkg::*;
#(
  parameter int NUM_TAPS      = 8,
  parameter int DATA_W        = 32,
  parameter int COEFF_W       = 8,
  parameter int OUT_W         = 32,
  parameter int SHIFT         = 0,
  parameter int CLEAR_ON_LAST = 1
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic signed [DATA_W-1:0]    s00_axis_tdata,
  input  logic                        s00_axis_tvalid,
  input  logic                        s00_axis_tlast,
  output logic                        s00_axis_tready,
  output logic signed [OUT_W-1:0]     m00_axis_tdata,
  output logic                        m00_axis_tvalid,
  output logic                        m00_axis_tlast,
  input  logic                        m00_axis_tready,
  input  logic                        coeff_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0] coeff_addr,
  input  logic signed [COEFF_W-1:0]   coeff_data,
  output logic                        sat_out
);
  localparam int ACC_W = acc_width(DATA_W, COEFF_W, NUM_TAPS);
  localparam int AW    = $clog2(NUM_TAPS);

  logic signed [COEFF_W-1:0] coeff [NUM_TAPS];
  logic signed [ACC_W-1:0]   p [1:NUM_TAPS];
  logic signed [ACC_W-1:0]   c0_ext, x_ext, tap0;
  logic [MAX_W:0]            res;
  logic                      res_clip;
  logic [MAX_W-OUT_W-1:0]    res_unused;
  logic [OUT_W-1:0]          res_val;
  logic                      accept, clear_hist, sat_q;

  assign s00_axis_tready = ~m00_axis_tvalid | m00_axis_tready;
  assign accept          = s00_axis_tvalid & s00_axis_tready;
  assign clear_hist      = (CLEAR_ON_LAST != 0) && s00_axis_tlast;

  // Tap 0 feeds the output register directly, so it has no partial-sum register.
  assign p[NUM_TAPS] = '0;
  for (genvar k = 1; k < NUM_TAPS; k++) begin : g_tap
    fir_mac_stage #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .ACC_W(ACC_W)) u_stage (
      .clk     (clk),
      .rst     (rst_in),
      .coeff   (coeff[k]),
      .x       (s00_axis_tdata),
      .p_next  (p[k+1]),
      .advance (accept),
      .clear   (clear_hist),
      .p_k     (p[k])
    );
  end

  assign c0_ext = ACC_W'(coeff[0]);
  assign x_ext  = ACC_W'(s00_axis_tdata);
  assign tap0   = c0_ext * x_ext + p[1];
  assign res    = sat_round(MAX_W'(tap0), SHIFT, OUT_W);
  assign {res_clip, res_unused, res_val} = res;

  // Addresses beyond NUM_TAPS-1 match no entry and are dropped.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < NUM_TAPS; k++) coeff[k] <= '0;
    end else if (coeff_wr_en) begin
      for (int k = 0; k < NUM_TAPS; k++)
        if (coeff_addr == AW'(k)) coeff[k] <= coeff_data;
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
      sat_q           <= 1'b0;
    end else if (accept) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tlast  <= s00_axis_tlast;
      m00_axis_tdata  <= res_val;
      sat_q           <= res_clip;
    end else if (m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
    end
  end

  assign sat_out = sat_q & m00_axis_tvalid;
endmodule

// File: tb/tb_fir_stream_filter.sv
// tb/tb_fir_stream_filter.sv - directed self-checking bench for fir_stream_filter
module tb_fir_stream_filter;
  logic               clk = 1'b0;
  logic               rst_in;
  logic signed [31:0] s_tdata;
  logic               s_tvalid, s_tlast, m_tready;
  logic               coeff_wr_en;
  logic [2:0]         coeff_addr;
  logic signed [7:0]  coeff_data;

  logic signed [31:0] a_tdata;
  logic               a_tvalid, a_tlast, a_sat, s_tready;
  logic signed [7:0]  q_tdata;
  logic               q_tvalid, q_sat, q_tlast_unused, q_tready_unused;
  logic signed [31:0] r_tdata;
  logic               r_tvalid_unused, r_tlast_unused, r_sat_unused, r_tready_unused;
  logic signed [31:0] n_tdata;
  logic               n_tvalid_unused, n_tlast_unused, n_sat_unused, n_tready_unused;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fir_stream_filter dut (
    .clk(clk), .rst_in(rst_in),
    .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tready(s_tready),
    .m00_axis_tdata(a_tdata), .m00_axis_tvalid(a_tvalid), .m00_axis_tlast(a_tlast),
    .m00_axis_tready(m_tready),
    .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .sat_out(a_sat));

  fir_stream_filter #(.OUT_W(8)) dut_sat (
    .clk(clk), .rst_in(rst_in),
    .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tready(q_tready_unused),
    .m00_axis_tdata(q_tdata), .m00_axis_tvalid(q_tvalid), .m00_axis_tlast(q_tlast_unused),
    .m00_axis_tready(m_tready),
    .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .sat_out(q_sat));

  fir_stream_filter #(.SHIFT(2)) dut_rnd (
    .clk(clk), .rst_in(rst_in),
    .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tready(r_tready_unused),
    .m00_axis_tdata(r_tdata), .m00_axis_tvalid(r_tvalid_unused), .m00_axis_tlast(r_tlast_unused),
    .m00_axis_tready(m_tready),
    .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .sat_out(r_sat_unused));

  fir_stream_filter #(.CLEAR_ON_LAST(0)) dut_nc (
    .clk(clk), .rst_in(rst_in),
    .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tready(n_tready_unused),
    .m00_axis_tdata(n_tdata), .m00_axis_tvalid(n_tvalid_unused), .m00_axis_tlast(n_tlast_unused),
    .m00_axis_tready(m_tready),
    .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .sat_out(n_sat_unused));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; coeff_wr_en = 1'b0; m_tready = 1'b1;
    tick();
    rst_in = 1'b0;
    tick();
  endtask

  task automatic set_coeff(input logic [2:0] addr, input logic signed [7:0] val);
    coeff_wr_en = 1'b1; coeff_addr = addr; coeff_data = val;
    tick();
    coeff_wr_en = 1'b0;
  endtask

  task automatic send(input logic signed [31:0] x, input logic last);
    s_tvalid = 1'b1; s_tdata = x; s_tlast = last;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1;
    coeff_wr_en = 1'b0; coeff_addr = '0; coeff_data = '0;
    tick();
    n_cmp++; if (a_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got %b want 0", a_tvalid); end
    n_cmp++; if (a_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast got %b want 0", a_tlast); end
    n_cmp++; if (a_tdata !== 32'sd0) begin n_bad++; $display("FAIL reset_tdata got %0d want 0", a_tdata); end
    n_cmp++; if (a_sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat got %b want 0", a_sat); end
    n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("FAIL reset_tready got %b want 1", s_tready); end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_identity();
    int xs[3] = '{5, -3, 7};
    do_reset();
    set_coeff(3'd0, 8'sd1);
    for (int i = 0; i < 3; i++) begin
      send(xs[i], 1'b0);
      n_cmp++; if (a_tvalid !== 1'b1) begin n_bad++; $display("FAIL ident_valid[%0d] got %b want 1", i, a_tvalid); end
      n_cmp++; if (a_tdata !== xs[i]) begin n_bad++; $display("FAIL ident_data[%0d] got %0d want %0d", i, a_tdata, xs[i]); end
    end
    tick();
    n_cmp++; if (a_tvalid !== 1'b0) begin n_bad++; $display("FAIL ident_drain got %b want 0", a_tvalid); end
  endtask

  task automatic test_impulse();
    int xs[6] = '{1, 0, 0, 0, 0, 0};
    int ys[6] = '{1, 2, 3, 0, 0, 0};
    do_reset();
    set_coeff(3'd0, 8'sd1); set_coeff(3'd1, 8'sd2); set_coeff(3'd2, 8'sd3);
    for (int i = 0; i < 6; i++) begin
      send(xs[i], i == 5);
      n_cmp++; if (a_tdata !== ys[i]) begin n_bad++; $display("FAIL impulse_data[%0d] got %0d want %0d", i, a_tdata, ys[i]); end
      n_cmp++; if (a_tlast !== (i == 5)) begin n_bad++; $display("FAIL impulse_last[%0d] got %b want %b", i, a_tlast, i == 5); end
    end
  endtask

  task automatic test_clear_on_last();
    int ya[5] = '{1, 2, 3, 1, 2};
    int yn[5] = '{1, 2, 3, 3, 3};
    do_reset();
    set_coeff(3'd0, 8'sd1); set_coeff(3'd1, 8'sd1); set_coeff(3'd2, 8'sd1);
    for (int i = 0; i < 5; i++) begin
      send(32'sd1, i == 2);
      n_cmp++; if (a_tdata !== ya[i]) begin n_bad++; $display("FAIL clear_data[%0d] got %0d want %0d", i, a_tdata, ya[i]); end
      n_cmp++; if (n_tdata !== yn[i]) begin n_bad++; $display("FAIL noclear_data[%0d] got %0d want %0d", i, n_tdata, yn[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_coeff(3'd0, 8'sd1);
    send(32'sd10, 1'b0);
    n_cmp++; if (a_tdata !== 32'sd10) begin n_bad++; $display("FAIL bp_first got %0d want 10", a_tdata); end
    m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 32'sd11;
    #1;
    n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low got %b want 0", s_tready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (a_tdata !== 32'sd10 || a_tvalid !== 1'b1) begin n_bad++; $display("FAIL bp_hold[%0d] got %0d/%b want 10/1", i, a_tdata, a_tvalid); end
      n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL bp_stall[%0d] got %b want 0", i, s_tready); end
    end
    m_tready = 1'b1;
    #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_high got %b want 1", s_tready); end
    tick();
    n_cmp++; if (a_tdata !== 32'sd11) begin n_bad++; $display("FAIL bp_release got %0d want 11", a_tdata); end
    s_tdata = 32'sd12;
    tick();
    n_cmp++; if (a_tdata !== 32'sd12) begin n_bad++; $display("FAIL bp_next got %0d want 12", a_tdata); end
    s_tvalid = 1'b0;
    tick();
    n_cmp++; if (a_tvalid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", a_tvalid); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_coeff(3'd0, 8'sd127);
    send(32'sd100, 1'b0);
    n_cmp++; if (q_tdata !== 8'sd127 || q_sat !== 1'b1) begin n_bad++; $display("FAIL sat_pos got %0d/%b want 127/1", q_tdata, q_sat); end
    n_cmp++; if (a_tdata !== 32'sd12700 || a_sat !== 1'b0) begin n_bad++; $display("FAIL wide_pos got %0d/%b want 12700/0", a_tdata, a_sat); end
    send(-32'sd100, 1'b0);
    n_cmp++; if (q_tdata !== -8'sd128 || q_sat !== 1'b1) begin n_bad++; $display("FAIL sat_neg got %0d/%b want -128/1", q_tdata, q_sat); end
    send(32'sd1, 1'b0);
    n_cmp++; if (q_tdata !== 8'sd127 || q_sat !== 1'b0) begin n_bad++; $display("FAIL sat_edge got %0d/%b want 127/0", q_tdata, q_sat); end
    tick();
    n_cmp++; if (q_tvalid !== 1'b0 || q_sat !== 1'b0) begin n_bad++; $display("FAIL sat_idle got %b/%b want 0/0", q_tvalid, q_sat); end
  endtask

  task automatic test_rounding();
    int xs[4] = '{6, -6, 5, 7};
    int ys[4] = '{2, -1, 1, 2};
    do_reset();
    set_coeff(3'd0, 8'sd1);
    for (int i = 0; i < 4; i++) begin
      send(xs[i], 1'b0);
      n_cmp++; if (r_tdata !== ys[i]) begin n_bad++; $display("FAIL round[%0d] got %0d want %0d", i, r_tdata, ys[i]); end
    end
  endtask

  task automatic test_coeff_coincident();
    do_reset();
    set_coeff(3'd0, 8'sd1);
    coeff_wr_en = 1'b1; coeff_addr = 3'd0; coeff_data = 8'sd5;
    s_tvalid = 1'b1; s_tdata = 32'sd3;
    tick();
    coeff_wr_en = 1'b0; s_tvalid = 1'b0;
    n_cmp++; if (a_tdata !== 32'sd3) begin n_bad++; $display("FAIL coeff_old got %0d want 3", a_tdata); end
    send(32'sd3, 1'b0);
    n_cmp++; if (a_tdata !== 32'sd15) begin n_bad++; $display("FAIL coeff_new got %0d want 15", a_tdata); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_coeff(3'd0, 8'sd1); set_coeff(3'd1, 8'sd1);
    send(32'sd4, 1'b0);
    send(32'sd4, 1'b0);
    n_cmp++; if (a_tdata !== 32'sd8) begin n_bad++; $display("FAIL mid_hist got %0d want 8", a_tdata); end
    m_tready = 1'b0;
    rst_in = 1'b1;
    #1;
    n_cmp++; if (a_tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_async got %b want 0", a_tvalid); end
    rst_in = 1'b0;
    m_tready = 1'b1;
    tick();
    set_coeff(3'd0, 8'sd1); set_coeff(3'd1, 8'sd1);
    send(32'sd2, 1'b0);
    n_cmp++; if (a_tdata !== 32'sd2) begin n_bad++; $display("FAIL mid_fresh got %0d want 2", a_tdata); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_impulse();
    test_clear_on_last();
    test_backpressure();
    test_saturation();
    test_rounding();
    test_coeff_coincident();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
